// File: rtl/bdc_target_responder_if.sv
// BKGD target link bundle: raw line sense/drive plus byte-level tx/rx handshakes.
// master = host-side user/line model, slave = bdc_target_responder.
interface bdc_target_responder_if;
    logic       bkgd_in;
    logic       bkgd_out;
    logic       bkgd_is_high_z;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sync_seen;
    logic       busy;

    modport master (
        output bkgd_in, tx_data, tx_load,
        input  bkgd_out, bkgd_is_high_z, tx_ready, tx_done, rx_data, rx_valid, sync_seen, busy
    );

    modport slave (
        input  bkgd_in, tx_data, tx_load,
        output bkgd_out, bkgd_is_high_z, tx_ready, tx_done, rx_data, rx_valid, sync_seen, busy
    );
endinterface

// File: rtl/bdc_target_responder.sv
// BKGD target: decodes host bit cells MSB first, answers SYNC, returns tx bytes; BDC_SPEEDUP_EN adds a 1-tick active-high pulse after SYNC.
// Line sensed through 2-flop sync + edge detect (3 clk); tx_load is taken only while tx_ready, otherwise dropped.
module bdc_target_responder #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_TICK  = 10,
    parameter int DRIVE0_TICKS = 13,
    parameter int SYNC_MIN     = 128,
    parameter int SYNC_DELAY   = 16,
    parameter int SYNC_RESP    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    bdc_target_responder_if.slave bdc
);
    localparam int              DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [7:0]      SMP_T    = 8'(SAMPLE_TICK);
    localparam logic [7:0]      DRV0_T   = 8'(DRIVE0_TICKS);
    localparam logic [7:0]      SMIN_T   = 8'(SYNC_MIN);
    localparam logic [7:0]      SDLY_T   = 8'(SYNC_DELAY);
    localparam logic [7:0]      SRSP_T   = 8'(SYNC_RESP);

`ifdef BDC_SPEEDUP_EN
    typedef enum logic [2:0] {IDLE, BIT, SYNC_WAIT, SYNC_DRIVE, SPEEDUP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BIT, SYNC_WAIT, SYNC_DRIVE} state_t;
`endif

    state_t        state;
    logic          sync1, line_s, line_q, fall;
    logic [DW-1:0] div;
    logic          tick;
    logic [7:0]    cnt, cnt_inc, cnt_nx;
    logic          smp, cell_tx;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic          tx_busy, tx_ready_q, tx_done_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, sync_seen_q, busy_q, hi_z_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            line_s <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= bdc.bkgd_in;
            line_s <= sync1;
            line_q <= line_s;
        end
    end

    assign fall = line_q & ~line_s;

    // Divider restarts on an accepted edge so tick boundaries line up with the host's cell start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if ((state == IDLE && fall) || tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick    = (div == DIV_LAST);
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign cnt_nx  = tick ? cnt_inc : cnt;

`ifdef BDC_SPEEDUP_EN
    logic out_q;
    assign bdc.bkgd_out = out_q;
`else
    assign bdc.bkgd_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            smp         <= 1'b0;
            cell_tx     <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_sh       <= 7'd0;
            tx_sh       <= 8'd0;
            tx_busy     <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            sync_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            hi_z_q      <= 1'b1;
`ifdef BDC_SPEEDUP_EN
            out_q       <= 1'b0;
`endif
        end else begin
            tx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            sync_seen_q <= 1'b0;

            if (bdc.tx_load && tx_ready_q) begin
                tx_sh      <= bdc.tx_data;
                tx_busy    <= 1'b1;
                tx_ready_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= BIT;
                        busy_q  <= 1'b1;
                        cnt     <= 8'd0;
                        smp     <= 1'b1;
                        // A byte loaded mid-cell must not start driving until the next cell.
                        cell_tx <= tx_busy;
                        hi_z_q  <= ~(tx_busy & ~tx_sh[7]);
                    end
                end

                BIT: begin
                    cnt    <= cnt_nx;
                    hi_z_q <= ~(cell_tx & ~tx_sh[7] & (cnt_nx < DRV0_T));
                    if (tick && cnt_inc == SMP_T)
                        smp <= line_s;
                    if (line_s && cnt >= SMP_T && hi_z_q) begin
                        cnt    <= 8'd0;
                        hi_z_q <= 1'b1;
                        if (cnt >= SMIN_T) begin
                            state      <= SYNC_WAIT;
                            bit_cnt    <= 3'd0;
                            tx_busy    <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (cell_tx) begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                                if (bit_cnt == 3'd7) begin
                                    tx_busy    <= 1'b0;
                                    tx_ready_q <= 1'b1;
                                    tx_done_q  <= 1'b1;
                                end
                            end else begin
                                rx_sh <= {rx_sh[5:0], smp};
                                if (bit_cnt == 3'd7) begin
                                    rx_data_q  <= {rx_sh, smp};
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                SYNC_WAIT: begin
                    if (tick) begin
                        if (cnt_inc == SDLY_T) begin
                            state  <= SYNC_DRIVE;
                            cnt    <= 8'd0;
                            hi_z_q <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                SYNC_DRIVE: begin
                    if (tick) begin
                        if (cnt_inc == SRSP_T) begin
                            cnt         <= 8'd0;
                            sync_seen_q <= 1'b1;
`ifdef BDC_SPEEDUP_EN
                            state  <= SPEEDUP;
                            out_q  <= 1'b1;
`else
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            hi_z_q <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

`ifdef BDC_SPEEDUP_EN
                SPEEDUP: begin
                    if (tick) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        hi_z_q <= 1'b1;
                        out_q  <= 1'b0;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    hi_z_q <= 1'b1;
                end
            endcase
        end
    end

    assign bdc.bkgd_is_high_z = hi_z_q;
    assign bdc.tx_ready       = tx_ready_q;
    assign bdc.tx_done        = tx_done_q;
    assign bdc.rx_data        = rx_data_q;
    assign bdc.rx_valid       = rx_valid_q;
    assign bdc.sync_seen      = sync_seen_q;
    assign bdc.busy           = busy_q;
endmodule
